// File: rtl/mutex_rule_scheduler.sv
// Round-robin rule-firing scheduler for the mutual-exclusion system model.
// Fires one guard-enabled rule per SAMPLE/FIRE pair, with single-step and deadlock detection.
module mutex_rule_scheduler #(
  parameter int NUM_RULES      = 12,
  parameter int IDX_W          = 4,
  parameter int DEADLOCK_LIMIT = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 run,
  input  logic                 step,
  input  logic [NUM_RULES-1:0] guard,
  output logic [IDX_W-1:0]     io_en_a,
  output logic                 en_valid,
  output logic                 deadlock,
  output logic [15:0]          fire_count
);

  typedef enum logic [1:0] {IDLE, SAMPLE, FIRE, DEAD} state_e;

  localparam logic [IDX_W-1:0] IDLE_CODE  = '1;
  localparam logic [7:0]       STALL_LAST = 8'(DEADLOCK_LIMIT - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [7:0]       stall_q, stall_d;
  logic             oneshot_q, oneshot_d;
  logic             deadlock_q, deadlock_d;
  logic [IDX_W-1:0] io_en_q, io_en_d;
  logic             en_valid_q, en_valid_d;
  logic [15:0]      fire_cnt_q, fire_cnt_d;

  logic             hi_found, lo_found;
  logic [IDX_W-1:0] hi_idx, lo_idx, win_idx, next_ptr;

  // Descending scan so the last hit is the lowest index; hi covers j >= ptr, lo covers wrap.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int j = NUM_RULES - 1; j >= 0; j--) begin
      if (guard[j]) begin
        lo_found = 1'b1;
        lo_idx   = IDX_W'(j);
        if (j >= int'(ptr_q)) begin
          hi_found = 1'b1;
          hi_idx   = IDX_W'(j);
        end
      end
    end
    win_idx  = hi_found ? hi_idx : lo_idx;
    next_ptr = (win_idx == IDX_W'(NUM_RULES - 1)) ? '0 : win_idx + IDX_W'(1);
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    stall_d    = '0;
    oneshot_d  = oneshot_q;
    deadlock_d = deadlock_q;
    io_en_d    = IDLE_CODE;
    en_valid_d = 1'b0;
    fire_cnt_d = fire_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (run) begin
          state_d = SAMPLE;
        end else if (step) begin
          state_d   = SAMPLE;
          oneshot_d = 1'b1;
        end
      end
      SAMPLE: begin
        // A single-step request must complete even though run is low.
        if (!run && !oneshot_q) begin
          state_d = IDLE;
        end else if (lo_found) begin
          state_d    = FIRE;
          io_en_d    = win_idx;
          en_valid_d = 1'b1;
          ptr_d      = next_ptr;
          deadlock_d = 1'b0;
        end else if (stall_q == STALL_LAST) begin
          state_d    = DEAD;
          deadlock_d = 1'b1;
        end else begin
          stall_d = stall_q + 8'd1;
        end
      end
      FIRE: begin
        if (fire_cnt_q != 16'hFFFF) fire_cnt_d = fire_cnt_q + 16'd1;
        if (run && !oneshot_q) begin
          state_d = SAMPLE;
        end else begin
          state_d   = IDLE;
          oneshot_d = 1'b0;
        end
      end
      DEAD: begin
        if (!run) begin
          state_d   = IDLE;
          oneshot_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      stall_q    <= '0;
      oneshot_q  <= 1'b0;
      deadlock_q <= 1'b0;
      io_en_q    <= IDLE_CODE;
      en_valid_q <= 1'b0;
      fire_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      stall_q    <= stall_d;
      oneshot_q  <= oneshot_d;
      deadlock_q <= deadlock_d;
      io_en_q    <= io_en_d;
      en_valid_q <= en_valid_d;
      fire_cnt_q <= fire_cnt_d;
    end
  end

  assign io_en_a    = io_en_q;
  assign en_valid   = en_valid_q;
  assign deadlock   = deadlock_q;
  assign fire_count = fire_cnt_q;

endmodule

// File: tb/tb_mutex_rule_scheduler.sv
// Self-checking bench for mutex_rule_scheduler: directed scenarios plus a
// randomized run compared against a rotate-and-search round-robin model.
module tb_mutex_rule_scheduler;

  localparam int N = 12;

  logic        clock = 1'b0;
  logic        reset_n, run, step;
  logic [11:0] guard;
  logic [3:0]  io_en_a;
  logic        en_valid, deadlock;
  logic [15:0] fire_count;

  int checks   = 0;
  int failures = 0;
  int mPtr     = 0;
  int mCount   = 0;

  always #5 clock = ~clock;

  mutex_rule_scheduler #(.NUM_RULES(12), .IDX_W(4), .DEADLOCK_LIMIT(8)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .run        (run),
    .step       (step),
    .guard      (guard),
    .io_en_a    (io_en_a),
    .en_valid   (en_valid),
    .deadlock   (deadlock),
    .fire_count (fire_count)
  );

  // Round-robin as written in words: first set guard found rotating from the pointer.
  function automatic int rrPick(input logic [11:0] g, input int p);
    for (int off = 0; off < N; off++) begin
      if (g[(p + off) % N]) return (p + off) % N;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    run     = 1'b0;
    step    = 1'b0;
    guard   = 12'($urandom);
    tick();
    tick();
    reset_n = 1'b1;
    mPtr    = 0;
    mCount  = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (io_en_a !== 4'hF)     begin failures++; $display("[TB] FAIL reset_io: got %h want f", io_en_a); end
    checks++; if (en_valid !== 1'b0)    begin failures++; $display("[TB] FAIL reset_valid: got %b want 0", en_valid); end
    checks++; if (deadlock !== 1'b0)    begin failures++; $display("[TB] FAIL reset_deadlock: got %b want 0", deadlock); end
    checks++; if (fire_count !== 16'd0) begin failures++; $display("[TB] FAIL reset_count: got %0d want 0", fire_count); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (en_valid !== 1'b0 || io_en_a !== 4'hF) begin
        failures++; $display("[TB] FAIL idle_hold: got valid=%b io=%h want valid=0 io=f", en_valid, io_en_a);
      end
    end
  endtask

  task automatic test_round_robin();
    int exp;
    guard = 12'h011;
    run   = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (en_valid !== 1'b0) begin failures++; $display("[TB] FAIL rr_sample_valid: got %b want 0", en_valid); end
      checks++; if (fire_count !== 16'(mCount)) begin failures++; $display("[TB] FAIL rr_count: got %0d want %0d", fire_count, mCount); end
      tick();
      exp  = rrPick(guard, mPtr);
      mPtr = (exp + 1) % N;
      mCount++;
      checks++;
      if (en_valid !== 1'b1 || io_en_a !== 4'(exp)) begin
        failures++; $display("[TB] FAIL rr_fire%0d: got valid=%b io=%0d want valid=1 io=%0d", k, en_valid, io_en_a, exp);
      end
    end
    run = 1'b0;
    tick();
    checks++; if (fire_count !== 16'd4) begin failures++; $display("[TB] FAIL rr_total: got %0d want 4", fire_count); end
    checks++; if (en_valid !== 1'b0) begin failures++; $display("[TB] FAIL rr_stop: got %b want 0", en_valid); end
  endtask

  task automatic test_wrap();
    apply_reset();
    guard = 12'hFFF;
    run   = 1'b1;
    for (int k = 0; k < 13; k++) begin
      tick();
      tick();
      checks++;
      if (en_valid !== 1'b1 || io_en_a !== 4'(k % N)) begin
        failures++; $display("[TB] FAIL wrap_fire%0d: got valid=%b io=%0d want valid=1 io=%0d", k, en_valid, io_en_a, k % N);
      end
    end
    run = 1'b0;
    tick();
    checks++; if (fire_count !== 16'd13) begin failures++; $display("[TB] FAIL wrap_count: got %0d want 13", fire_count); end
  endtask

  task automatic test_random();
    int          zeros   = 0;
    bit          expFire = 1'b0;
    int          expIdx  = 0;
    logic [11:0] g;
    apply_reset();
    run   = 1'b1;
    guard = 12'hFFF;
    tick();
    for (int c = 0; c < 300; c++) begin
      checks++; if (en_valid !== expFire) begin failures++; $display("[TB] FAIL rand_valid c=%0d: got %b want %b", c, en_valid, expFire); end
      if (expFire) begin
        checks++; if (io_en_a !== 4'(expIdx)) begin failures++; $display("[TB] FAIL rand_idx c=%0d: got %0d want %0d", c, io_en_a, expIdx); end
      end
      checks++; if (fire_count !== 16'(mCount)) begin failures++; $display("[TB] FAIL rand_count c=%0d: got %0d want %0d", c, fire_count, mCount); end
      g = 12'($urandom);
      if ($urandom_range(3) == 0) g = 12'h000;
      if (g == 12'h000) zeros++; else zeros = 0;
      if (zeros >= 5) begin
        g     = 12'h001 << $urandom_range(11);
        zeros = 0;
      end
      guard = g;
      if (expFire) begin
        mCount++;
        expFire = 1'b0;
      end else if (g != 12'h000) begin
        expIdx  = rrPick(g, mPtr);
        mPtr    = (expIdx + 1) % N;
        expFire = 1'b1;
      end
      tick();
    end
    if (expFire) mCount++;
    run = 1'b0;
    tick();
    checks++; if (en_valid !== 1'b0) begin failures++; $display("[TB] FAIL rand_stop: got %b want 0", en_valid); end
    tick();
    checks++; if (fire_count !== 16'(mCount)) begin failures++; $display("[TB] FAIL rand_final_count: got %0d want %0d", fire_count, mCount); end
  endtask

  task automatic test_deadlock();
    apply_reset();
    guard = 12'h000;
    run   = 1'b1;
    tick();
    for (int i = 1; i <= 8; i++) begin
      checks++;
      if (deadlock !== 1'b0 || en_valid !== 1'b0) begin
        failures++; $display("[TB] FAIL dl_early%0d: got dl=%b valid=%b want dl=0 valid=0", i, deadlock, en_valid);
      end
      tick();
    end
    checks++; if (deadlock !== 1'b1) begin failures++; $display("[TB] FAIL dl_flag: got %b want 1", deadlock); end
    guard = 12'h004;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (deadlock !== 1'b1 || en_valid !== 1'b0) begin
        failures++; $display("[TB] FAIL dl_hold%0d: got dl=%b valid=%b want dl=1 valid=0", i, deadlock, en_valid);
      end
    end
    run = 1'b0;
    tick();
    checks++; if (deadlock !== 1'b1) begin failures++; $display("[TB] FAIL dl_idle_sticky: got %b want 1", deadlock); end
    run = 1'b1;
    tick();
    tick();
    checks++;
    if (en_valid !== 1'b1 || io_en_a !== 4'd2) begin
      failures++; $display("[TB] FAIL dl_recover_fire: got valid=%b io=%0d want valid=1 io=2", en_valid, io_en_a);
    end
    checks++; if (deadlock !== 1'b0) begin failures++; $display("[TB] FAIL dl_clear: got %b want 0", deadlock); end
    run = 1'b0;
    tick();
    checks++; if (fire_count !== 16'd1) begin failures++; $display("[TB] FAIL dl_count: got %0d want 1", fire_count); end
  endtask

  task automatic test_single_step();
    int pulses = 0;
    apply_reset();
    run   = 1'b0;
    guard = 12'h020;
    step  = 1'b1;
    tick();
    step = 1'b0;
    checks++; if (en_valid !== 1'b0) begin failures++; $display("[TB] FAIL step_sample: got %b want 0", en_valid); end
    tick();
    checks++;
    if (en_valid !== 1'b1 || io_en_a !== 4'd5) begin
      failures++; $display("[TB] FAIL step_fire: got valid=%b io=%0d want valid=1 io=5", en_valid, io_en_a);
    end
    step = 1'b1;
    tick();
    step = 1'b0;
    checks++;
    if (en_valid !== 1'b0 || io_en_a !== 4'hF) begin
      failures++; $display("[TB] FAIL step_after: got valid=%b io=%h want valid=0 io=f", en_valid, io_en_a);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      if (en_valid === 1'b1) pulses++;
    end
    checks++; if (pulses != 0) begin failures++; $display("[TB] FAIL step_extra_pulses: got %0d want 0", pulses); end
    checks++; if (fire_count !== 16'd1) begin failures++; $display("[TB] FAIL step_count: got %0d want 1", fire_count); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    guard = 12'($urandom_range(12'h7FF, 1));
    run   = 1'b1;
    tick();
    tick();
    checks++; if (en_valid !== 1'b1) begin failures++; $display("[TB] FAIL mid_prefire: got %b want 1", en_valid); end
    reset_n = 1'b0;
    tick();
    checks++;
    if (en_valid !== 1'b0 || io_en_a !== 4'hF || fire_count !== 16'd0) begin
      failures++; $display("[TB] FAIL mid_reset: got valid=%b io=%h cnt=%0d want valid=0 io=f cnt=0", en_valid, io_en_a, fire_count);
    end
    reset_n = 1'b1;
    guard   = 12'hFFF;
    tick();
    tick();
    checks++;
    if (en_valid !== 1'b1 || io_en_a !== 4'd0) begin
      failures++; $display("[TB] FAIL mid_ptr_cleared: got valid=%b io=%0d want valid=1 io=0", en_valid, io_en_a);
    end
    run = 1'b0;
    tick();
  endtask

  initial begin
    reset_n = 1'b0;
    run     = 1'b0;
    step    = 1'b0;
    guard   = 12'h000;
    test_reset();
    test_round_robin();
    test_wrap();
    test_deadlock();
    test_single_step();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mutex_rule_scheduler.md
# mutex_rule_scheduler

Rule-firing scheduler for the generated mutual-exclusion `system` model. It drives that model's encoded rule-enable input `io_en_a` so that only rules whose guards are currently true are fired. Among enabled rules it picks one at a time in round-robin order. It also provides a single-step debug mode, a deadlock detector and a saturating fire counter, and it sits between the stimulus/control layer and `system`.

## Interface
- `NUM_RULES`, 12: number of rules (3 nodes × Try/Crit/Exit/Idle); rule index i maps to guard bit i.
- `IDX_W`, 4: width of the encoded rule index; `2**IDX_W - 1` must be ≥ `NUM_RULES`.
- `DEADLOCK_LIMIT`, 8: consecutive guard-empty SAMPLE cycles before deadlock is flagged; range 1..255.
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `run`  in  1  level: 1 = free-running scheduling, 0 = stop after the current FIRE.
- `step`  in  1  one-cycle pulse: fire exactly one rule; honoured only in IDLE with `run`=0.
- `guard`  in  NUM_RULES  per-rule guard vector from `system`, combinational from its state.
- `io_en_a`  out  IDX_W  encoded rule to fire; `IDLE_CODE` = all ones when no rule is fired.
- `en_valid`  out  1  high exactly in FIRE cycles.
- `deadlock`  out  1  sticky flag: no guard true for `DEADLOCK_LIMIT` consecutive samples.
- `fire_count`  out  16  number of FIRE cycles since reset, saturating at 16'hFFFF.

## Operation
- States:
  - IDLE: not scheduling.
  - SAMPLE: guards are evaluated.
  - FIRE: one rule is driven.
  - DEAD: deadlock has been flagged.
- Reset (`reset_n`=0 at an edge):
  - state = IDLE, `io_en_a` = IDLE_CODE, `en_valid` = 0.
  - `deadlock` = 0, `fire_count` = 0, round-robin pointer `ptr` = 0, stall counter = 0.
- IDLE:
  - `run`=1 → SAMPLE.
  - else `step`=1 → SAMPLE with the one-shot flag set.
  - else stay in IDLE.
- SAMPLE:
  - Winner = lowest index j ≥ `ptr` with `guard[j]`=1. If none exists, wrap and take the lowest j < `ptr` with `guard[j]`=1.
  - Winner found → register `io_en_a` = j and `en_valid` = 1, go to FIRE, set `ptr` = (j+1) mod NUM_RULES, clear the stall counter.
  - No guard set → stay in SAMPLE and increment the stall counter.
  - Stall counter reaches `DEADLOCK_LIMIT` → DEAD, `deadlock` = 1.
- FIRE (exactly one cycle): `system` updates on the closing edge.
  - `fire_count` += 1 unless already saturated.
  - Next state: SAMPLE if `run`=1 and the one-shot flag is clear; otherwise IDLE, clearing the one-shot flag.
  - On leaving FIRE, `io_en_a` returns to IDLE_CODE and `en_valid` to 0.
- DEAD:
  - `io_en_a` = IDLE_CODE, `en_valid` = 0.
  - Leaves only when `run`=0, going to IDLE.
  - `deadlock` stays 1 until reset, or until the first SAMPLE→FIRE transition after DEAD is left.
- `run` falling during SAMPLE → IDLE next cycle; no fire is issued.
- `step` is ignored outside IDLE and whenever `run`=1.
- Only `reset_n` clears `ptr`; stopping and restarting keeps round-robin fairness.

## Timing
- All outputs are registered; nothing is combinational from input to output.
- From `run`=1 sampled in IDLE at edge k:
  - SAMPLE occupies cycle k+1.
  - FIRE occupies cycle k+2 (`en_valid`=1).
  - With guards continuously non-empty, FIRE recurs every 2 cycles: k+2, k+4, …
- The SAMPLE cycle sees guards from the post-fire state, so a stale guard is never used.
- Deadlock is flagged at the edge ending the `DEADLOCK_LIMIT`-th consecutive empty SAMPLE. With the default limit this is 8 cycles after entering SAMPLE.
- `reset_n`=0 during FIRE → `en_valid`=0 in the next cycle; no `fire_count` increment for that cycle.
- `fire_count` changes on the edge ending FIRE and is visible in the following cycle.

## Test plan
- Reset:
  - Stimulus: hold `reset_n`=0 for 2 cycles, then release.
  - Required: `io_en_a`=4'hF, `en_valid`=0, `deadlock`=0, `fire_count`=0; IDLE persists while `run`=0.
- Round-robin:
  - Stimulus: `guard`=12'h011, `run`=1.
  - Required: FIRE sequence `io_en_a` = 0, 4, 0, 4 at 2-cycle spacing; `fire_count`=4 after the 4th fire.
- Wrap-around:
  - Stimulus: `guard`=12'hFFF from reset.
  - Required: `io_en_a` = 0, 1, …, 11, 0; the 13th fire is index 0.
- Deadlock:
  - Stimulus: `guard`=0, `run`=1.
  - Required: `deadlock`=1 after 8 empty SAMPLE cycles; `en_valid` stays 0. Raising `guard`=12'h004 keeps DEAD until `run`=0. After `run` drops and rises again, the first fire is index 2 and `deadlock` clears.
- Single step:
  - Stimulus: `run`=0, `guard`=12'h020, one `step` pulse.
  - Required: exactly one `en_valid` pulse with `io_en_a`=5, 2 cycles after the pulse, then IDLE; a second `step` during that FIRE is ignored.
- Reset mid-operation:
  - Stimulus: `reset_n`=0 in a FIRE cycle.
  - Required: the next cycle has `en_valid`=0, `io_en_a`=4'hF, `fire_count`=0, `ptr`=0.
